// File: rtl/video_out_timing_if.sv
// rtl/video_out_timing_if.sv - framebuffer read-side and video DAC signal bundle
// Optional testbars input present when VIDEO_OUT_TESTBARS_EN is defined.
interface video_out_timing_if;
  logic [2:0] fb_pixel;
  logic       fb_data_en;
  logic       fb_reset_rd;
  logic [2:0] rgb_out;
  logic       hsync_n;
  logic       vsync_n;
  logic       csync_n;
  logic       blank_n;
  logic       field;
  logic       frame_start;
`ifdef VIDEO_OUT_TESTBARS_EN
  logic       testbars;

  modport master (
    input  fb_pixel, testbars,
    output fb_data_en, fb_reset_rd, rgb_out, hsync_n, vsync_n, csync_n,
           blank_n, field, frame_start
  );
  modport slave (
    output fb_pixel, testbars,
    input  fb_data_en, fb_reset_rd, rgb_out, hsync_n, vsync_n, csync_n,
           blank_n, field, frame_start
  );
`else
  modport master (
    input  fb_pixel,
    output fb_data_en, fb_reset_rd, rgb_out, hsync_n, vsync_n, csync_n,
           blank_n, field, frame_start
  );
  modport slave (
    output fb_pixel,
    input  fb_data_en, fb_reset_rd, rgb_out, hsync_n, vsync_n, csync_n,
           blank_n, field, frame_start
  );
`endif
endinterface

// File: rtl/video_out_timing.sv
// rtl/video_out_timing.sv - PAL 625/864 raster timing, framebuffer read control and blanked RGB out
// Optional colour-bar generator enabled by VIDEO_OUT_TESTBARS_EN.
module video_out_timing #(
  parameter int H_TOTAL     = 864,
  parameter int H_SYNC_LEN  = 64,
  parameter int H_ACT_START = 132,
  parameter int H_ACT_LEN   = 720,
  parameter int V_TOTAL     = 625,
  parameter int V_SYNC_LEN  = 3,
  parameter int V_FIELD2    = 313,
  parameter int V_ACT_START = 23,
  parameter int V_ACT_LEN   = 288,
  parameter int RGB_DLY     = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          clkPhase,
  input  logic                enable,
  video_out_timing_if.master  vif
);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_END    = 10'(H_SYNC_LEN);
  localparam logic [9:0] HA_BEG    = 10'(H_ACT_START);
  localparam logic [9:0] HA_END    = 10'(H_ACT_START + H_ACT_LEN);
  localparam logic [9:0] VS_END    = 10'(V_SYNC_LEN);
  localparam logic [9:0] F2_BEG    = 10'(V_FIELD2);
  localparam logic [9:0] F2_VS_END = 10'(V_FIELD2 + V_SYNC_LEN);
  localparam logic [9:0] VA0_BEG   = 10'(V_ACT_START);
  localparam logic [9:0] VA0_END   = 10'(V_ACT_START + V_ACT_LEN);
  localparam logic [9:0] VA1_BEG   = 10'(V_FIELD2 + V_ACT_START);
  localparam logic [9:0] VA1_END   = 10'(V_FIELD2 + V_ACT_START + V_ACT_LEN);

  logic               tick;
  logic               running;
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic [9:0]         h_nxt;
  logic [9:0]         v_nxt;
  logic               line_act;
  logic               de_nxt;
  logic               hs_nxt;
  logic               vs_nxt;
  logic               origin_nxt;
  logic [2:0]         pix_src;
  logic [2:0]         pix_in;

  logic               de_q;
  logic               rrd_q;
  logic               hs_q;
  logic               vs_q;
  logic               cs_q;
  logic               field_q;
  logic               fs_q;
  logic [RGB_DLY-1:0] act_sr;
  logic [2:0]         pix_sr [RGB_DLY];

  // Everything advances on the phase-5 edge so the framebuffer sees stable controls at phase 0.
  assign tick = (clkPhase == 3'd5);

  // The first enabled tick parks the raster at the origin instead of advancing it.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (running) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
      end
    end
  end

  always_comb begin
    line_act   = ((v_nxt >= VA0_BEG) && (v_nxt < VA0_END)) ||
                 ((v_nxt >= VA1_BEG) && (v_nxt < VA1_END));
    de_nxt     = line_act && (h_nxt >= HA_BEG) && (h_nxt < HA_END);
    hs_nxt     = !(h_nxt < HS_END);
    vs_nxt     = !((v_nxt < VS_END) || ((v_nxt >= F2_BEG) && (v_nxt < F2_VS_END)));
    origin_nxt = (h_nxt == 10'd0) && (v_nxt == 10'd0);
  end

`ifdef VIDEO_OUT_TESTBARS_EN
  localparam int BAR_W = H_ACT_LEN / 8;

  logic [9:0] h_rel;
  logic [2:0] bar_idx;
  logic [2:0] bar_rgb;

  // h_cnt is the position that the current fb_data_en belongs to.
  always_comb begin
    h_rel   = h_cnt - HA_BEG;
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_rel >= 10'(BAR_W * k)) bar_idx = 3'(k);
    end
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  assign pix_src = vif.testbars ? bar_rgb : vif.fb_pixel;
`else
  assign pix_src = vif.fb_pixel;
`endif

  // Gating at the entry keeps rgb_out at zero whenever the delayed active flag is low.
  assign pix_in = de_q ? pix_src : 3'b000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      de_q    <= 1'b0;
      rrd_q   <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      cs_q    <= 1'b1;
      field_q <= 1'b0;
      fs_q    <= 1'b0;
      act_sr  <= '0;
      for (int i = 0; i < RGB_DLY; i++) pix_sr[i] <= 3'b000;
    end else begin
      fs_q <= 1'b0;
      if (tick) begin
        if (!enable) begin
          running <= 1'b0;
          h_cnt   <= '0;
          v_cnt   <= '0;
          de_q    <= 1'b0;
          rrd_q   <= 1'b0;
          hs_q    <= 1'b1;
          vs_q    <= 1'b1;
          cs_q    <= 1'b1;
          field_q <= 1'b0;
          act_sr  <= '0;
          for (int i = 0; i < RGB_DLY; i++) pix_sr[i] <= 3'b000;
        end else begin
          running   <= 1'b1;
          h_cnt     <= h_nxt;
          v_cnt     <= v_nxt;
          de_q      <= de_nxt;
          rrd_q     <= origin_nxt;
          fs_q      <= origin_nxt;
          hs_q      <= hs_nxt;
          vs_q      <= vs_nxt;
          cs_q      <= hs_nxt & vs_nxt;
          field_q   <= (v_nxt >= F2_BEG);
          act_sr[0] <= de_q;
          pix_sr[0] <= pix_in;
          for (int i = 1; i < RGB_DLY; i++) begin
            act_sr[i] <= act_sr[i-1];
            pix_sr[i] <= pix_sr[i-1];
          end
        end
      end
    end
  end

  assign vif.fb_data_en  = de_q;
  assign vif.fb_reset_rd = rrd_q;
  assign vif.hsync_n     = hs_q;
  assign vif.vsync_n     = vs_q;
  assign vif.csync_n     = cs_q;
  assign vif.field       = field_q;
  assign vif.frame_start = fs_q;
  assign vif.blank_n     = act_sr[RGB_DLY-1];
  assign vif.rgb_out     = pix_sr[RGB_DLY-1];

endmodule

// File: tb/tb_video_out_timing.sv
// tb/tb_video_out_timing.sv - table-driven bench: full-size raster start plus a shrunken raster for frame-level checks
module tb_video_out_timing;

  logic       clk;
  logic       reset_n;
  logic [2:0] clk_phase;
  logic       en_d;
  logic       en_s;
  bit         fast;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  video_out_timing_if vif_d();
  video_out_timing_if vif_s();

  video_out_timing dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clkPhase (clk_phase),
    .enable   (en_d),
    .vif      (vif_d)
  );

  video_out_timing #(
    .H_TOTAL(16), .H_SYNC_LEN(2), .H_ACT_START(5), .H_ACT_LEN(8),
    .V_TOTAL(13), .V_SYNC_LEN(2), .V_FIELD2(7), .V_ACT_START(3), .V_ACT_LEN(3),
    .RGB_DLY(2)
  ) dut_s (
    .clk      (clk),
    .reset_n  (reset_n),
    .clkPhase (clk_phase),
    .enable   (en_s),
    .vif      (vif_s)
  );

`ifdef VIDEO_OUT_TESTBARS_EN
  initial begin
    vif_d.testbars = 1'b0;
    vif_s.testbars = 1'b0;
  end
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // In fast mode every edge is a pixel tick; otherwise the phase cycles 0..5.
  initial begin
    clk_phase = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      if (fast) clk_phase = 3'd5;
      else      clk_phase = (clk_phase == 3'd5) ? 3'd0 : clk_phase + 3'd1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int         v;
    int         h;
    logic [9:0] exp;
  } vec_t;

  vec_t tab_d [17];
  vec_t tab_s [22];

  function automatic logic [9:0] ev(input logic de, input logic hs, input logic vs, input logic cs,
                                    input logic fld, input logic blk, input logic [2:0] rgb,
                                    input logic rrd);
    return {de, hs, vs, cs, fld, blk, rgb, rrd};
  endfunction

  function automatic logic [9:0] got_d();
    return {vif_d.fb_data_en, vif_d.hsync_n, vif_d.vsync_n, vif_d.csync_n, vif_d.field,
            vif_d.blank_n, vif_d.rgb_out, vif_d.fb_reset_rd};
  endfunction

  function automatic logic [9:0] got_s();
    return {vif_s.fb_data_en, vif_s.hsync_n, vif_s.vsync_n, vif_s.csync_n, vif_s.field,
            vif_s.blank_n, vif_s.rgb_out, vif_s.fb_reset_rd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic step();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 16 && !ok; n++) begin
      @(posedge clk);
      if (clk_phase == 3'd5) ok = 1'b1;
    end
    #2;
    if (!ok) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  logic [9:0] idle_v;
  int t_d, ts, tgt;
  int de_line, first_de, rrd_hi, fs_hi, hs_lo, bad;
  int de_frm, rrd_frm, fs_frm;

  initial begin
    idle_v = ev(0, 1, 1, 1, 0, 0, 3'b000, 0);

    // Full-size raster, fb_pixel = 101.
    tab_d[0]  = '{0,   1,   ev(0, 0, 0, 0, 0, 0, 3'b000, 0)};
    tab_d[1]  = '{0,   63,  ev(0, 0, 0, 0, 0, 0, 3'b000, 0)};
    tab_d[2]  = '{0,   64,  ev(0, 1, 0, 0, 0, 0, 3'b000, 0)};
    tab_d[3]  = '{2,   100, ev(0, 1, 0, 0, 0, 0, 3'b000, 0)};
    tab_d[4]  = '{3,   0,   ev(0, 0, 1, 0, 0, 0, 3'b000, 0)};
    tab_d[5]  = '{3,   64,  ev(0, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_d[6]  = '{22,  132, ev(0, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_d[7]  = '{23,  131, ev(0, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_d[8]  = '{23,  132, ev(1, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_d[9]  = '{23,  133, ev(1, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_d[10] = '{23,  134, ev(1, 1, 1, 1, 0, 1, 3'b101, 0)};
    tab_d[11] = '{23,  851, ev(1, 1, 1, 1, 0, 1, 3'b101, 0)};
    tab_d[12] = '{23,  852, ev(0, 1, 1, 1, 0, 1, 3'b101, 0)};
    tab_d[13] = '{23,  853, ev(0, 1, 1, 1, 0, 1, 3'b101, 0)};
    tab_d[14] = '{23,  854, ev(0, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_d[15] = '{24,  0,   ev(0, 0, 1, 0, 0, 0, 3'b000, 0)};
    tab_d[16] = '{24,  132, ev(1, 1, 1, 1, 0, 0, 3'b000, 0)};

    // Shrunken raster 16x13: hsync h<2, vsync lines 0-1 and 7-8, active h 5..12 on lines 3-5 and 10-12, fb_pixel = 110.
    tab_s[0]  = '{0,  0,  ev(0, 0, 0, 0, 0, 0, 3'b000, 1)};
    tab_s[1]  = '{0,  2,  ev(0, 1, 0, 0, 0, 0, 3'b000, 0)};
    tab_s[2]  = '{1,  15, ev(0, 1, 0, 0, 0, 0, 3'b000, 0)};
    tab_s[3]  = '{2,  0,  ev(0, 0, 1, 0, 0, 0, 3'b000, 0)};
    tab_s[4]  = '{2,  2,  ev(0, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_s[5]  = '{3,  5,  ev(1, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_s[6]  = '{3,  7,  ev(1, 1, 1, 1, 0, 1, 3'b110, 0)};
    tab_s[7]  = '{3,  12, ev(1, 1, 1, 1, 0, 1, 3'b110, 0)};
    tab_s[8]  = '{3,  13, ev(0, 1, 1, 1, 0, 1, 3'b110, 0)};
    tab_s[9]  = '{3,  15, ev(0, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_s[10] = '{5,  12, ev(1, 1, 1, 1, 0, 1, 3'b110, 0)};
    tab_s[11] = '{6,  5,  ev(0, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_s[12] = '{6,  7,  ev(0, 1, 1, 1, 0, 0, 3'b000, 0)};
    tab_s[13] = '{7,  0,  ev(0, 0, 0, 0, 1, 0, 3'b000, 0)};
    tab_s[14] = '{8,  3,  ev(0, 1, 0, 0, 1, 0, 3'b000, 0)};
    tab_s[15] = '{9,  3,  ev(0, 1, 1, 1, 1, 0, 3'b000, 0)};
    tab_s[16] = '{10, 5,  ev(1, 1, 1, 1, 1, 0, 3'b000, 0)};
    tab_s[17] = '{10, 7,  ev(1, 1, 1, 1, 1, 1, 3'b110, 0)};
    tab_s[18] = '{12, 12, ev(1, 1, 1, 1, 1, 1, 3'b110, 0)};
    tab_s[19] = '{12, 15, ev(0, 1, 1, 1, 1, 0, 3'b000, 0)};
    tab_s[20] = '{13, 0,  ev(0, 0, 0, 0, 0, 0, 3'b000, 1)};
    tab_s[21] = '{13, 1,  ev(0, 0, 0, 0, 0, 0, 3'b000, 0)};

    reset_n = 1'b0;
    fast    = 1'b0;
    en_d    = 1'b0;
    en_s    = 1'b0;
    vif_d.fb_pixel = 3'b101;
    vif_s.fb_pixel = 3'b110;

    #25;
    chk("reset_dflt", got_d(), idle_v);
    chk("reset_dflt_fs", vif_d.frame_start, 0);
    chk("reset_small", got_s(), idle_v);

    @(posedge clk);
    #2;
    reset_n = 1'b1;
    en_d    = 1'b1;

    // First tick lands on the origin; reset pulse spans one full tick, frame_start one clk.
    step();
    t_d = 0;
    chk("start_vec", got_d(), ev(0, 0, 0, 0, 0, 0, 3'b000, 1));
    chk("start_fs", vif_d.frame_start, 1);
    rrd_hi = 1;
    fs_hi  = 1;
    hs_lo  = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      rrd_hi += vif_d.fb_reset_rd;
      fs_hi  += vif_d.frame_start;
      hs_lo  += !vif_d.hsync_n;
    end
    chk("rrd_width_clks", rrd_hi, 6);
    chk("fs_width_clks", fs_hi, 1);
    chk("hsync_hold", hs_lo, 6);
    step();
    t_d = 1;
    chk("rrd_drop", vif_d.fb_reset_rd, 0);

    fast     = 1'b1;
    de_line  = 0;
    first_de = -1;
    for (int i = 0; i < 17; i++) begin
      tgt = tab_d[i].v * 864 + tab_d[i].h;
      while (t_d < tgt) begin
        step();
        t_d++;
        if (t_d / 864 == 23 && vif_d.fb_data_en) de_line++;
        if (vif_d.fb_data_en && first_de < 0) first_de = t_d;
      end
      chk($sformatf("dflt_v%0d_h%0d", tab_d[i].v, tab_d[i].h), got_d(), tab_d[i].exp);
    end
    chk("de_per_line", de_line, 720);
    chk("first_de_tick", first_de, 23 * 864 + 132);

    // Asynchronous reset in the middle of an active line.
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_vec", got_d(), idle_v);
    chk("async_rst_fs", vif_d.frame_start, 0);
    fast = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      if (got_d() !== idle_v || vif_d.frame_start !== 1'b0) bad++;
    end
    chk("idle_until_tick", bad, 0);
    step();
    chk("restart_after_rst", got_d(), ev(0, 0, 0, 0, 0, 0, 3'b000, 1));

    // Shrunken raster: full frame walk, wrap, and per-frame counts.
    en_s = 1'b1;
    fast = 1'b1;
    step();
    ts      = 0;
    de_frm  = 0;
    rrd_frm = vif_s.fb_reset_rd;
    fs_frm  = vif_s.frame_start;
    for (int i = 0; i < 22; i++) begin
      tgt = tab_s[i].v * 16 + tab_s[i].h;
      while (ts < tgt) begin
        step();
        ts++;
        if (ts < 208) begin
          de_frm  += vif_s.fb_data_en;
          rrd_frm += vif_s.fb_reset_rd;
        end
        if (ts <= 208) fs_frm += vif_s.frame_start;
      end
      chk($sformatf("small_v%0d_h%0d", tab_s[i].v, tab_s[i].h), got_s(), tab_s[i].exp);
    end
    chk("small_de_per_frame", de_frm, 48);
    chk("small_rrd_per_frame", rrd_frm, 1);
    chk("small_fs_two_frames", fs_frm, 2);

    // Drop enable mid-active-line, hold 50 clks, then restart at the origin.
    while (ts < 264) begin
      step();
      ts++;
    end
    chk("pre_disable_de", vif_s.fb_data_en, 1);
    fast = 1'b0;
    en_s = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    chk("disabled_vec", got_s(), idle_v);
    chk("disabled_fs", vif_s.frame_start, 0);
    en_s = 1'b1;
    step();
    chk("reenable_vec", got_s(), ev(0, 0, 0, 0, 0, 0, 3'b000, 1));
    chk("reenable_fs", vif_s.frame_start, 1);
    step();
    chk("reenable_next", got_s(), ev(0, 0, 0, 0, 0, 0, 3'b000, 0));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
